// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encoding and index width helper for the adder datapath
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_t;

  // Operand index width; never narrower than one bit.
  function automatic int idx_width(input int n_ops);
    return (n_ops > 2) ? $clog2(n_ops) : 1;
  endfunction

endpackage

// File: rtl/accumulator_ctrl.sv
// rtl/accumulator_ctrl.sv - sequencing FSM, operand index counter and handshake decode
module accumulator_ctrl
  import adder_pkg::*;
#(
  parameter int N_OPS = 4,
  parameter int IDX_W = idx_width(N_OPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             out_ready,
  output logic             capture,
  output logic             acc_en,
  output logic             last,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             o_valid
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPS - 1);

  acc_state_t state;
  acc_state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ACC;
      ST_ACC:  if (idx == IDX_LAST) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = start ? ST_ACC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // busy/o_valid depend on state only; capture is the one input-qualified strobe.
  always_comb begin
    capture = 1'b0;
    acc_en  = 1'b0;
    busy    = 1'b0;
    o_valid = 1'b0;
    case (state)
      ST_IDLE: capture = start;
      ST_ACC: begin
        acc_en = 1'b1;
        busy   = 1'b1;
      end
      ST_DONE: begin
        busy    = 1'b1;
        o_valid = 1'b1;
        capture = start & out_ready;
      end
      default: ;
    endcase
  end

  assign last = acc_en & (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (capture || last) begin
      idx <= '0;
    end else if (acc_en) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/multi_operand_accumulator.sv
// rtl/multi_operand_accumulator.sv - sequential N-operand adder with wrap/saturate and valid/ready result
module multi_operand_accumulator
  import adder_pkg::*;
#(
  parameter int N_OPS = 4,
  parameter int IN_W  = 4,
  parameter int SUM_W = 16,
  parameter int SAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_OPS*IN_W-1:0] ops,
  output logic                  busy,
  output logic                  o_valid,
  input  logic                  out_ready,
  output logic [SUM_W-1:0]      o_sum,
  output logic                  overflow
);

  localparam int IDX_W = idx_width(N_OPS);

  logic                  capture;
  logic                  acc_en;
  logic                  last;
  logic [IDX_W-1:0]      idx;
  logic [N_OPS*IN_W-1:0] bank;
  logic [SUM_W-1:0]      acc;
  logic [SUM_W-1:0]      acc_nxt;
  logic                  ovf_flag;
  logic [IN_W-1:0]       operand;
  logic [SUM_W:0]        sum_ext;
  logic                  carry;

  accumulator_ctrl #(
    .N_OPS (N_OPS),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .out_ready (out_ready),
    .capture   (capture),
    .acc_en    (acc_en),
    .last      (last),
    .idx       (idx),
    .busy      (busy),
    .o_valid   (o_valid)
  );

  always_comb begin
    operand = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (idx == IDX_W'(i)) operand = bank[i*IN_W +: IN_W];
    end
  end

  // One extra bit on the adder exposes the carry out of SUM_W.
  assign sum_ext = {1'b0, acc} + {{(SUM_W + 1 - IN_W){1'b0}}, operand};
  assign carry   = sum_ext[SUM_W];
  assign acc_nxt = ((SAT != 0) && carry) ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank     <= '0;
      acc      <= '0;
      ovf_flag <= 1'b0;
      o_sum    <= '0;
      overflow <= 1'b0;
    end else if (capture) begin
      bank     <= ops;
      acc      <= '0;
      ovf_flag <= 1'b0;
    end else if (acc_en) begin
      acc      <= acc_nxt;
      ovf_flag <= ovf_flag | carry;
      if (last) begin
        o_sum    <= acc_nxt;
        overflow <= ovf_flag | carry;
      end
    end
  end

endmodule

// File: doc/multi_operand_accumulator.md
# multi_operand_accumulator

Parametrised successor to the four-operand adder datapath. It captures `N_OPS` unsigned operands in one cycle, then sums them sequentially, one operand per clock, into a `SUM_W`-bit accumulator. The accumulator runs under an internal FSM rather than external load/select strobes. It presents the result with a valid/ready handshake, plus a sticky overflow flag and an optional saturating mode. It sits between the operand source and the result consumer in the adder datapath.

## Interface
- `N_OPS`, 4: number of operands per transaction; range 2..16.
- `IN_W`, 4: width of each operand in bits.
- `SUM_W`, 16: width of the accumulator and result; must be ≥ `IN_W`.
- `SAT`, 0: 0 = wrap modulo 2^`SUM_W`; 1 = saturate at all-ones.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request to capture operands; sampled in IDLE, or in DONE together with `out_ready`.
- `ops` input `N_OPS*IN_W`: packed operands; operand i is `ops[i*IN_W +: IN_W]`.
- `busy` output 1: high in ACC and in DONE.
- `o_valid` output 1: high in DONE; the result is available.
- `out_ready` input 1: consumer accepts the result while `o_valid` is high.
- `o_sum` output `SUM_W`: result register.
- `overflow` output 1: at least one addition in this transaction exceeded `SUM_W` bits.

## Operation
- FSM states: IDLE, ACC, DONE. Binary encoded; reset state is IDLE.
- IDLE:
  - If `start` = 1 at a rising edge: latch all of `ops` into the operand bank, clear `acc` and `idx` to 0, clear the internal overflow flag, and go to ACC.
  - Otherwise stay in IDLE.
- ACC:
  - Each cycle: `acc` ← `acc` + bank[`idx`], with the operand zero-extended to `SUM_W`+1 bits.
  - If bit `SUM_W` of that sum is 1, set the internal overflow flag.
  - When `SAT`=1 and that bit is 1, `acc` ← all-ones. Once saturated, `acc` stays at all-ones for the rest of the transaction.
  - `idx` increments by 1 each cycle. When `idx` = `N_OPS`-1, the final sum is written to both `acc` and `o_sum`, the internal flag (including this cycle's carry) goes to `overflow`, and the FSM moves to DONE.
- DONE:
  - `o_valid` = 1; `o_sum` and `overflow` are stable.
  - If `out_ready` = 0: stay in DONE.
  - If `out_ready` = 1 and `start` = 0: go to IDLE.
  - If `out_ready` = 1 and `start` = 1: accept the result and capture the new `ops` in the same edge (as in IDLE), then go to ACC. This is back-to-back operation with no idle cycle.
- `start` is ignored in ACC, and in DONE when `out_ready` = 0. The operand bank is never rewritten during ACC.
- `o_sum` and `overflow` change only on the edge that enters DONE. They hold their values through IDLE and the next ACC until the next DONE.
- `o_valid` and `busy` are decoded from the registered state, with no combinational path from the inputs.

## Timing
- Reset values: state IDLE, `o_sum` 0, `overflow` 0, `o_valid` 0, `busy` 0. The accumulator, operand bank and `idx` are also 0.
- Latency: `start` accepted at edge k → `o_valid` is high after edge k+`N_OPS`.
- Throughput, back-to-back with `out_ready` held high: one result every `N_OPS`+1 cycles.
- `rst` asserted in any state, including mid-ACC or in DONE with `o_valid` high:
  - All registers return to their reset values immediately.
  - The partial sum is discarded and no result is presented.
  - The first accepted `start` after release starts a clean transaction.
- `out_ready` outside DONE has no effect.

## Structure
- Shared package `adder_pkg`:
  - state encoding constants `ST_IDLE`=2'd0, `ST_ACC`=2'd1, `ST_DONE`=2'd2;
  - `clog2`-based width helper for `idx`.
- Natural split: `accumulator_ctrl` sub-module holding the FSM, `idx` counter and handshake decode. It drives `capture`, `acc_en` and `last` to the top level.
- The top level holds the operand bank, the adder, the saturation logic and the output registers.

## Test plan
- Defaults, operands {3,5,7,9}, `start` pulsed, `out_ready`=1 → `o_valid` high after 4 edges, `o_sum`=24, `overflow`=0; IDLE on the next edge.
- `IN_W`=8, `SUM_W`=8, `SAT`=0, operands {200,100,0,0} → `o_sum`=44, `overflow`=1. Same operands with `SAT`=1 → `o_sum`=255, `overflow`=1.
- `out_ready` held 0 for 5 cycles in DONE with `o_sum`=24 → `o_valid` and `o_sum` stable. `start` pulses in that window are ignored; the result is accepted on the first cycle `out_ready`=1.
- Back-to-back: `start` and `out_ready` both held high, operands {1,1,1,1} then {15,15,15,15} → results 4 then 60, five cycles apart.
- `rst` pulsed on the second ACC cycle → all outputs 0 and state IDLE. A following transaction with {2,2,2,2} → 8.
- `N_OPS`=16, all operands 15 → `o_sum`=240 after 16 cycles; `ops` changing during ACC does not affect the result.
